// File: rtl/eth_tx_pkg.sv
// Shared controller state type, frame-size constants and CRC helpers for the RMII transmit path.
package eth_tx_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        PREAMBLE  = 4'd1,
        SFD       = 4'd2,
        DEST_ADDR = 4'd3,
        SRC_ADDR  = 4'd4,
        LEN_TYPE  = 4'd5,
        DATA      = 4'd6,
        PAD       = 4'd7,
        FCS       = 4'd8,
        IPG       = 4'd9
    } eth_tx_ctrl_state_t;

    localparam int cPREAMBLE_BYTES    = 7;
    localparam int cSFD_BYTES         = 1;
    localparam int cMAC_BYTES         = 6;
    localparam int cLEN_TYPE_BYTES    = 2;
    localparam int cMIN_PAYLOAD_BYTES = 46;
    localparam int cFCS_BYTES         = 4;
    localparam int cIPG_BYTES         = 12;
    localparam int cDIBITS_PER_BYTE   = 4;

    localparam logic [7:0]  cPREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  cSFD_BYTE      = 8'hD5;
    localparam logic [31:0] cCRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] cCRC_POLY_R    = 32'hEDB8_8320;

    // Two serial steps of the reflected CRC, din[0] is the first bit on the wire.
    function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] din);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ din[i]) begin
                c = (c >> 1) ^ cCRC_POLY_R;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            3'd5:    b = mac[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [1:0] byte_dibit(input logic [7:0] b, input logic [1:0] sel);
        logic [1:0] d;
        case (sel)
            2'd0:    d = b[1:0];
            2'd1:    d = b[3:2];
            2'd2:    d = b[5:4];
            default: d = b[7:6];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/eth_tx_crc32.sv
// Ethernet CRC-32 (reflected, init all-ones) advancing two bits per clock.
module eth_tx_crc32
    import eth_tx_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Init,
    input  logic        En,
    input  logic [1:0]  Din,
    output logic [31:0] Crc
);

    always_ff @(posedge Clk) begin
        if (Rst || Init) begin
            Crc <= cCRC_INIT;
        end else if (En) begin
            Crc <= crc32_dibit(Crc, Din);
        end
    end

endmodule

// File: rtl/eth_tx_serializer.sv
// RMII transmit dibit generator following the eth_tx_ctrl state; inline FCS generation.
// Optional frame counter port Frame_Cnt is built only when ETH_TX_STATS_EN is defined.
module eth_tx_serializer
    import eth_tx_pkg::*;
#(
    parameter logic [47:0] pDEST_MAC  = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] pSRC_MAC   = 48'h0200_0000_0001,
    parameter logic [15:0] pETHERTYPE = 16'h88B5
) (
    input  logic               Clk,
    input  logic               Rst,
    input  eth_tx_ctrl_state_t Tx_Ctrl_FSM_State,
    input  logic               Tx_En,
    input  logic               Crc_En,
    input  logic               Fifo_Rd,
    input  logic [7:0]         Fifo_Data,
    output logic [1:0]         Rmii_Txd,
    output logic               Rmii_Tx_En
`ifdef ETH_TX_STATS_EN
    ,
    output logic [15:0]        Frame_Cnt
`endif
);

    eth_tx_ctrl_state_t rState;
    logic [1:0]         rDib;
    logic [2:0]         rIdx;
    logic [7:0]         rNext;
    logic [7:0]         rSh;
    logic               rRdPend;

    logic               state_chg;
    logic [1:0]         dib_cur;
    logic [2:0]         idx_cur;
    logic [7:0]         tx_byte;
    logic [1:0]         gen_dibit;
    logic [31:0]        crc;
    logic [31:0]        fcs;
    logic [4:0]         fcs_sel;
    logic               crc_init;

    // A new state always starts at dibit 0 of byte 0, even though the registered counters lag a cycle.
    assign state_chg = (Tx_Ctrl_FSM_State != rState);
    assign dib_cur   = state_chg ? 2'd0 : rDib;
    assign idx_cur   = state_chg ? 3'd0 : rIdx;
    assign fcs       = ~crc;
    assign fcs_sel   = {idx_cur[1:0], dib_cur, 1'b0};
    assign crc_init  = (Tx_Ctrl_FSM_State == IDLE);

    always_comb begin
        tx_byte = 8'h00;
        case (Tx_Ctrl_FSM_State)
            PREAMBLE:  tx_byte = cPREAMBLE_BYTE;
            SFD:       tx_byte = cSFD_BYTE;
            DEST_ADDR: tx_byte = mac_byte(pDEST_MAC, idx_cur);
            SRC_ADDR:  tx_byte = mac_byte(pSRC_MAC, idx_cur);
            LEN_TYPE:  tx_byte = idx_cur[0] ? pETHERTYPE[7:0] : pETHERTYPE[15:8];
            DATA:      tx_byte = (dib_cur == 2'd0) ? rNext : rSh;
            PAD:       tx_byte = 8'h00;
            default:   tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        gen_dibit = 2'b00;
        if (Tx_Ctrl_FSM_State == FCS) begin
            gen_dibit = fcs[fcs_sel +: 2];
        end else begin
            gen_dibit = byte_dibit(tx_byte, dib_cur);
        end
    end

    eth_tx_crc32 u_crc (
        .Clk  (Clk),
        .Rst  (Rst),
        .Init (crc_init),
        .En   (Crc_En),
        .Din  (gen_dibit),
        .Crc  (crc)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rState <= IDLE;
            rDib   <= 2'd0;
            rIdx   <= 3'd0;
        end else begin
            rState <= Tx_Ctrl_FSM_State;
            if (Tx_En) begin
                rDib <= dib_cur + 2'd1;
                rIdx <= (dib_cur == 2'd3) ? idx_cur + 3'd1 : idx_cur;
            end else begin
                rDib <= 2'd0;
                rIdx <= 3'd0;
            end
        end
    end

    // The FIFO answers one clock after the strobe; rSh takes rNext at each data byte boundary.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rRdPend <= 1'b0;
            rNext   <= 8'h00;
            rSh     <= 8'h00;
        end else begin
            rRdPend <= Fifo_Rd;
            if (rRdPend) begin
                rNext <= Fifo_Data;
            end
            if (Tx_En && (Tx_Ctrl_FSM_State == DATA) && (dib_cur == 2'd0)) begin
                rSh <= rNext;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Rmii_Txd   <= 2'b00;
            Rmii_Tx_En <= 1'b0;
        end else begin
            Rmii_Tx_En <= Tx_En;
            Rmii_Txd   <= Tx_En ? gen_dibit : 2'b00;
        end
    end

`ifdef ETH_TX_STATS_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Frame_Cnt <= 16'h0000;
        end else if ((rState == FCS) && (Tx_Ctrl_FSM_State == IPG)) begin
            Frame_Cnt <= Frame_Cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_eth_tx_serializer.sv
// Scoreboard bench for eth_tx_serializer: a controller model drives frames, a monitor checks every RMII dibit.
module tb_eth_tx_serializer;
    import eth_tx_pkg::*;

    localparam logic [47:0] cDEST          = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] cSRC           = 48'h0200_0000_0001;
    localparam logic [15:0] cTYPE          = 16'h88B5;
    localparam int          cFRAME_DIBITS  = 288;

    logic               Clk = 1'b0;
    logic               Rst;
    eth_tx_ctrl_state_t Tx_Ctrl_FSM_State;
    logic               Tx_En;
    logic               Crc_En;
    logic               Fifo_Rd;
    logic [7:0]         Fifo_Data;
    logic [1:0]         Rmii_Txd;
    logic               Rmii_Tx_En;
`ifdef ETH_TX_STATS_EN
    logic [15:0]        Frame_Cnt;
`endif

    logic               crcInit;
    logic               crcEn;
    logic [1:0]         crcDin;
    logic [31:0]        crcOut;

    int                 checks = 0;
    int                 errors = 0;
    logic [1:0]         expQ[$];
    int                 expLenQ[$];
    logic [7:0]         fifoQ[$];
    logic [7:0]         payload[$];
    logic               rdPrev;
    int                 runLen = 0;
    bit                 monEn = 1'b0;
    logic [1:0]         monExp;
    int                 monLen;

    always #10 Clk = ~Clk;

    eth_tx_serializer #(
        .pDEST_MAC  (cDEST),
        .pSRC_MAC   (cSRC),
        .pETHERTYPE (cTYPE)
    ) dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .Tx_Ctrl_FSM_State (Tx_Ctrl_FSM_State),
        .Tx_En             (Tx_En),
        .Crc_En            (Crc_En),
        .Fifo_Rd           (Fifo_Rd),
        .Fifo_Data         (Fifo_Data),
        .Rmii_Txd          (Rmii_Txd),
        .Rmii_Tx_En        (Rmii_Tx_En)
`ifdef ETH_TX_STATS_EN
        ,
        .Frame_Cnt         (Frame_Cnt)
`endif
    );

    eth_tx_crc32 u_crc_alone (
        .Clk  (Clk),
        .Rst  (Rst),
        .Init (crcInit),
        .En   (crcEn),
        .Din  (crcDin),
        .Crc  (crcOut)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
        checks++;
        if (act !== expVal) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expVal, $time);
        end
    endtask

    // Byte-serial software CRC, independent of the dibit datapath.
    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // One controller cycle; the FIFO model answers a read on the following cycle.
    task automatic applyStimulus(input eth_tx_ctrl_state_t st, input logic txen, input logic crcen,
                                 input logic rd, input logic [1:0] expDib);
        @(negedge Clk);
        if (rdPrev) begin
            Fifo_Data = (fifoQ.size() > 0) ? fifoQ.pop_front() : 8'h00;
        end
        rdPrev            = rd;
        Tx_Ctrl_FSM_State = st;
        Tx_En             = txen;
        Crc_En            = crcen;
        Fifo_Rd           = rd;
        if (txen) begin
            expQ.push_back(expDib);
        end
    endtask

    // abortAt < 0 sends a full frame; otherwise stop before data byte abortAt via Rst or a Tx_En drop.
    task automatic sendFrame(input int abortAt, input bit abortWithRst);
        logic [7:0]         fb[$];
        eth_tx_ctrl_state_t fs[$];
        logic [47:0]        mac;
        logic [15:0]        etype;
        logic [31:0]        crc;
        logic [31:0]        fcs;
        logic [7:0]         b;
        logic [1:0]         sfdDib[4];
        logic               rd;
        int                 n;
        int                 dataIdx;

        n = payload.size();
        fifoQ = payload;
        mac = cDEST;
        for (int i = 0; i < 6; i++) begin
            fb.push_back(mac[8*(5-i) +: 8]);
            fs.push_back(DEST_ADDR);
        end
        mac = cSRC;
        for (int i = 0; i < 6; i++) begin
            fb.push_back(mac[8*(5-i) +: 8]);
            fs.push_back(SRC_ADDR);
        end
        etype = cTYPE;
        fb.push_back(etype[15:8]);
        fs.push_back(LEN_TYPE);
        fb.push_back(etype[7:0]);
        fs.push_back(LEN_TYPE);
        for (int i = 0; i < n; i++) begin
            fb.push_back(payload[i]);
            fs.push_back(DATA);
        end
        for (int i = n; i < 46; i++) begin
            fb.push_back(8'h00);
            fs.push_back(PAD);
        end
        crc = 32'hFFFF_FFFF;
        foreach (fb[i]) crc = crcByte(crc, fb[i]);
        fcs = ~crc;
        for (int i = 0; i < 4; i++) begin
            fb.push_back(fcs[8*i +: 8]);
            fs.push_back(FCS);
        end

        if (abortAt < 0) expLenQ.push_back(cFRAME_DIBITS);
        else             expLenQ.push_back(4 * (8 + 14 + abortAt));

        applyStimulus(IDLE, 1'b0, 1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 28; i++) applyStimulus(PREAMBLE, 1'b1, 1'b0, 1'b0, 2'b01);
        sfdDib = '{2'b01, 2'b01, 2'b01, 2'b11};
        for (int j = 0; j < 4; j++) applyStimulus(SFD, 1'b1, 1'b0, 1'b0, sfdDib[j]);

        dataIdx = 0;
        for (int k = 0; k < fb.size(); k++) begin
            b = fb[k];
            for (int j = 0; j < 4; j++) begin
                if ((fs[k] == DATA) && (j == 0) && (dataIdx == abortAt)) begin
                    fifoQ.delete();
                    if (abortWithRst) begin
                        @(negedge Clk);
                        Rst = 1'b1;
                        Tx_Ctrl_FSM_State = IDLE;
                        Tx_En = 1'b0;
                        Crc_En = 1'b0;
                        Fifo_Rd = 1'b0;
                        rdPrev = 1'b0;
                        @(negedge Clk);
                        checkOutput("rst_mid_txen", 32'(Rmii_Tx_En), 32'd0);
                        checkOutput("rst_mid_txd", 32'(Rmii_Txd), 32'd0);
                        Rst = 1'b0;
                    end else begin
                        applyStimulus(IDLE, 1'b0, 1'b0, 1'b0, 2'b00);
                        rdPrev = 1'b0;
                        @(negedge Clk);
                        checkOutput("drop_txen", 32'(Rmii_Tx_En), 32'd0);
                    end
                    for (int i = 0; i < 4; i++) applyStimulus(IDLE, 1'b0, 1'b0, 1'b0, 2'b00);
                    return;
                end
                rd = (fs[k] == DATA) && (j == 0) && (dataIdx < n - 1);
                applyStimulus(fs[k], 1'b1, (fs[k] != FCS), rd, b[2*j +: 2]);
            end
            if (fs[k] == DATA) dataIdx++;
        end
        for (int i = 0; i < 48; i++) applyStimulus(IPG, 1'b0, 1'b0, 1'b0, 2'b00);
        applyStimulus(IDLE, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    // Monitor: pops an expected dibit for every enabled output cycle and checks burst lengths.
    always @(negedge Clk) begin
        if (monEn) begin
            if (Rmii_Tx_En === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL txd_unexpected: got dibit %b with no expected dibit at %0t", Rmii_Txd, $time);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("txd", 32'(Rmii_Txd), 32'(monExp));
                end
                runLen++;
            end else begin
                checkOutput("txd_idle", 32'(Rmii_Txd), 32'd0);
                if (runLen > 0) begin
                    if (expLenQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL txen_len: got %0d cycles with no expected length", runLen);
                    end else begin
                        monLen = expLenQ.pop_front();
                        checkOutput("txen_len", 32'(runLen), 32'(monLen));
                    end
                    runLen = 0;
                end
            end
        end
    end

    initial begin
        string      s;
        logic [7:0] ch;

        Rst = 1'b1;
        Tx_Ctrl_FSM_State = IDLE;
        Tx_En = 1'b0;
        Crc_En = 1'b0;
        Fifo_Rd = 1'b0;
        Fifo_Data = 8'h00;
        rdPrev = 1'b0;
        crcInit = 1'b0;
        crcEn = 1'b0;
        crcDin = 2'b00;
        repeat (3) @(negedge Clk);
        checkOutput("reset_txen", 32'(Rmii_Tx_En), 32'd0);
        checkOutput("reset_txd", 32'(Rmii_Txd), 32'd0);
        checkOutput("reset_crc", crcOut, 32'hFFFF_FFFF);
`ifdef ETH_TX_STATS_EN
        checkOutput("reset_frame_cnt", 32'(Frame_Cnt), 32'd0);
`endif
        Rst = 1'b0;
        monEn = 1'b1;

        s = "123456789";
        @(negedge Clk);
        crcInit = 1'b1;
        @(negedge Clk);
        crcInit = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ch = s[i];
            for (int j = 0; j < 4; j++) begin
                crcEn = 1'b1;
                crcDin = ch[2*j +: 2];
                @(negedge Clk);
            end
        end
        crcEn = 1'b0;
        checkOutput("crc_check_value", ~crcOut, 32'hCBF4_3926);
        @(negedge Clk);
        checkOutput("crc_hold", ~crcOut, 32'hCBF4_3926);

        payload.delete();
        for (int i = 0; i < 46; i++) payload.push_back(8'(i));
        sendFrame(-1, 1'b0);

        payload.delete();
        payload.push_back(8'hA5);
        sendFrame(-1, 1'b0);

        payload.delete();
        for (int i = 0; i < 20; i++) payload.push_back(8'(8'h30 + i));
        sendFrame(-1, 1'b0);
`ifdef ETH_TX_STATS_EN
        checkOutput("frame_cnt_3", 32'(Frame_Cnt), 32'd3);
`endif

        expLenQ.push_back(4);
        for (int i = 0; i < 4; i++) applyStimulus(eth_tx_ctrl_state_t'(4'hF), 1'b1, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) applyStimulus(IDLE, 1'b0, 1'b0, 1'b0, 2'b00);

        payload.delete();
        for (int i = 0; i < 46; i++) payload.push_back(8'(i));
        sendFrame(5, 1'b0);
        sendFrame(9, 1'b1);
`ifdef ETH_TX_STATS_EN
        checkOutput("frame_cnt_after_rst", 32'(Frame_Cnt), 32'd0);
`endif
        sendFrame(-1, 1'b0);
`ifdef ETH_TX_STATS_EN
        checkOutput("frame_cnt_1", 32'(Frame_Cnt), 32'd1);
`endif

        repeat (4) @(negedge Clk);
        checkOutput("exp_queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("len_queue_drained", 32'(expLenQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
